ct_seq_ctrl: RTL
================

// Module: ct_seq_ctrl
// PURPOSE
//  Sequencer in front of one CT_module (4x4 x 3x3 convolution engine). Loads kernel and tile from
//  a byte stream into holding registers. Drives the engine's reset/start, captures its serial
//  results into a buffer, and replays them on a ready/valid output stream. Supports kernel reuse
//  across tiles and a watchdog on the engine.
// PARAMETERS
//  N_RESULTS   4     results expected per run (2x2 output map)
//  TIMEOUT_CYC 255   max cycles in WAIT before abort; counter width = $clog2(TIMEOUT_CYC+1)
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    synchronous, active-high
//  start        in   1    run request; sampled only in IDLE
//  keep_kernel  in   1    with start: reuse stored kernel, skip kernel load (needs kern_ok=1)
//  in_valid     in   1    input byte valid
//  in_data      in   8    kernel bytes b_1_1..b_3_3, then tile bytes a_1_1..a_4_4, row-major
//  in_ready     out  1    high only in LOAD_K / LOAD_A
//  a_bus        out  128  a_r_c = a_bus[8*(4*(r-1)+(c-1)) +: 8], to CT_module a_* ports
//  b_bus        out  72   b_r_c = b_bus[8*(3*(r-1)+(c-1)) +: 8], to CT_module b_* ports
//  ct_reset     out  1    engine reset pulse
//  en_ct        out  1    engine start pulse
//  ct_en_result in   1    engine result strobe
//  ct_result    in   8    engine result byte
//  ct_done      in   1    engine completion
//  out_valid    out  1    result byte valid
//  out_data     out  8    result byte
//  out_last     out  1    with out_valid: final result of run
//  out_ready    in   1    downstream accept
//  busy         out  1    state != IDLE
//  kern_ok      out  1    a full kernel is stored
//  err_timeout  out  1    sticky; set on watchdog abort, cleared by next accepted start
//  err_count    out  1    sticky; set if result count != N_RESULTS at ct_done; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0; a_bus/b_bus=0; kern_ok=0; counters=0.
//  FSM: IDLE -> LOAD_K -> LOAD_A -> FIRE_R -> FIRE_E -> WAIT -> DRAIN -> IDLE.
//  IDLE: start=1 clears err_*. Next state is LOAD_A if keep_kernel&kern_ok, else LOAD_K.
//   keep_kernel=1 with kern_ok=0 goes to LOAD_K. start in any other state is ignored.
//  LOAD_K: each in_valid&in_ready writes the next b byte. kern_ok drops to 0 on the first write.
//   After the 9th byte, kern_ok=1 and the FSM goes to LOAD_A.
//  LOAD_A: same for 16 a bytes. After the 16th byte -> FIRE_R. No timeout while loading.
//  FIRE_R: ct_reset=1 for exactly 1 cycle -> FIRE_E.
//  FIRE_E: en_ct=1 for exactly 1 cycle. Clears the result count and watchdog -> WAIT.
//  a_bus/b_bus are stable from the end of LOAD_A until the next load write.
//  WAIT: each ct_en_result=1 stores ct_result in buf[cnt] if cnt<N_RESULTS, then cnt++ (saturates).
//   Strobes beyond N_RESULTS are dropped. ct_en_result and ct_done in the same cycle: the result
//   is captured first, then ct_done is evaluated with the updated count.
//   ct_done: err_count=(cnt!=N_RESULTS). If cnt>0 go to DRAIN, else IDLE.
//   Watchdog: reaching TIMEOUT_CYC cycles in WAIT sets err_timeout, pulses ct_reset for 1 cycle,
//   and goes to IDLE. Captured results are discarded.
//  DRAIN: out_valid=1, out_data=buf[idx], out_last=(idx==min(cnt,N_RESULTS)-1).
//   out_data holds while out_ready=0. Advance on out_valid&out_ready. After last -> IDLE.
//  Output is registered: out_valid falls the cycle after the last handshake.
//  reset mid-run: immediate return to IDLE. kern_ok=0, buffers invalid, no ct_reset/en_ct pulse.
//  Latency: after the final tile byte, ct_reset next cycle, en_ct the cycle after.
// TESTING
//  1 start(keep=0); feed 1..25 with in_valid stuck 1 -> 25 accepts; b_1_1=1, b_3_3=9, a_1_1=10,
//    a_4_4=25; ct_reset then en_ct one cycle each.
//  2 CT stub emits 11,22,33,44 then ct_done; out_ready=1 -> out 11,22,33,44, out_last only on 44.
//  3 Rerun with keep_kernel=1 and 16 bytes -> no LOAD_K, b_bus unchanged, 16 accepts, en_ct once.
//  4 Stub never asserts ct_done -> at 255 WAIT cycles err_timeout=1, ct_reset pulse, busy=0.
//  5 Stub emits 3 results + ct_done; out_ready toggles 1/0 -> err_count=1, 3 bytes, data held on stall.
//  6 reset asserted during LOAD_A -> next cycle busy=0, kern_ok=0; start keep=1 -> LOAD_K.

Source files
------------

// File: rtl/ct_seq_ctrl.sv
// Sequencer for one CT_module: loads kernel/tile bytes, fires the engine, captures its
// serial results and replays them on a ready/valid stream, with kernel reuse and a watchdog.
module ct_seq_ctrl #(
  parameter int unsigned N_RESULTS   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         keep_kernel,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] a_bus,
  output logic [71:0]  b_bus,
  output logic         ct_reset,
  output logic         en_ct,
  input  logic         ct_en_result,
  input  logic [7:0]   ct_result,
  input  logic         ct_done,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         kern_ok,
  output logic         err_timeout,
  output logic         err_count
);
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W   = $clog2(N_RESULTS + 2);
  localparam int unsigned IDX_W   = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1;
  localparam int unsigned LD_W    = 4;
  localparam int unsigned K_BYTES = 9;
  localparam int unsigned A_BYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_LOAD_A, S_FIRE_R, S_FIRE_E, S_WAIT, S_DRAIN
  } state_e;

  state_e                            state_q, state_d;
  logic [LD_W-1:0]                   ld_cnt_q, ld_cnt_d;
  logic [A_BYTES-1:0][7:0]           a_q, a_d;
  logic [K_BYTES-1:0][7:0]           b_q, b_d;
  logic [N_RESULTS-1:0][7:0]         res_q, res_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [WD_W-1:0]                   wd_q, wd_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic                              kern_ok_q, kern_ok_d;
  logic                              err_timeout_q, err_timeout_d;
  logic                              err_count_q, err_count_d;
  logic                              in_ready_q, in_ready_d;
  logic                              ct_reset_q, ct_reset_d;
  logic                              en_ct_q, en_ct_d;
  logic                              out_valid_q, out_valid_d;
  logic [7:0]                        out_data_q, out_data_d;
  logic                              out_last_q, out_last_d;
  logic                              busy_q, busy_d;
  logic                              accept;
  logic                              abort;
  logic [CNT_W-1:0]                  cnt_v;
  logic [IDX_W-1:0]                  last_idx;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    idx_d         = idx_q;
    kern_ok_d     = kern_ok_q;
    err_timeout_d = err_timeout_q;
    err_count_d   = err_count_q;
    abort         = 1'b0;
    cnt_v         = cnt_q;
    last_idx      = '0;
    accept        = in_valid & in_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_timeout_d = 1'b0;
          err_count_d   = 1'b0;
          ld_cnt_d      = '0;
          state_d       = (keep_kernel && kern_ok_q) ? S_LOAD_A : S_LOAD_K;
        end
      end
      S_LOAD_K: begin
        if (accept) begin
          b_d[ld_cnt_q] = in_data;
          kern_ok_d     = 1'b0;
          if (ld_cnt_q == LD_W'(K_BYTES - 1)) begin
            kern_ok_d = 1'b1;
            ld_cnt_d  = '0;
            state_d   = S_LOAD_A;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
          end
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          a_d[ld_cnt_q] = in_data;
          if (ld_cnt_q == LD_W'(A_BYTES - 1)) begin
            ld_cnt_d = '0;
            state_d  = S_FIRE_R;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
          end
        end
      end
      S_FIRE_R: state_d = S_FIRE_E;
      S_FIRE_E: begin
        cnt_d   = '0;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Capture happens before ct_done looks at the count
        if (ct_en_result) begin
          if (cnt_q < CNT_W'(N_RESULTS)) res_d[cnt_q[IDX_W-1:0]] = ct_result;
          if (cnt_q <= CNT_W'(N_RESULTS)) cnt_v = cnt_q + CNT_W'(1);
        end
        cnt_d = cnt_v;
        if (ct_done) begin
          err_count_d = (cnt_v != CNT_W'(N_RESULTS));
          idx_d       = '0;
          state_d     = (cnt_v != '0) ? S_DRAIN : S_IDLE;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          err_timeout_d = 1'b1;
          abort         = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) state_d = S_IDLE;
          else            idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cnt_d >= CNT_W'(N_RESULTS)) last_idx = IDX_W'(N_RESULTS - 1);
    else                            last_idx = IDX_W'(cnt_d - CNT_W'(1));

    in_ready_d  = (state_d == S_LOAD_K) || (state_d == S_LOAD_A);
    ct_reset_d  = (state_d == S_FIRE_R) || abort;
    en_ct_d     = (state_d == S_FIRE_E);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DRAIN);
    out_data_d  = out_valid_d ? res_d[idx_d] : 8'h00;
    out_last_d  = out_valid_d && (idx_d == last_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ld_cnt_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      idx_q         <= '0;
      kern_ok_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      ct_reset_q    <= 1'b0;
      en_ct_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_cnt_q      <= ld_cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      idx_q         <= idx_d;
      kern_ok_q     <= kern_ok_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
      in_ready_q    <= in_ready_d;
      ct_reset_q    <= ct_reset_d;
      en_ct_q       <= en_ct_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign a_bus       = a_q;
  assign b_bus       = b_q;
  assign ct_reset    = ct_reset_q;
  assign en_ct       = en_ct_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign kern_ok     = kern_ok_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;

endmodule
